// File: rtl/spi_dev_pkg.sv
// spi_dev_pkg: shared read-state encoding and default command bytes for spi_dev blocks
package spi_dev_pkg;
    typedef enum logic [1:0] {RD_IDLE, RD_STATUS, RD_DATA, RD_DONE} rd_state_t;
    localparam logic [7:0] CMD_WRITE = 8'hE2;
    localparam logic [7:0] CMD_READ  = 8'hE3;
endpackage

// File: rtl/spi_dev_sresp.sv
// spi_dev_sresp: streams FIFO response words as bytes on pw_rdata; SPI_SRESP_STATUS_EN adds a leading status byte
module spi_dev_sresp
    import spi_dev_pkg::*;
#(
    parameter logic [7:0] CMD_BYTE   = CMD_READ,
    parameter int         RSP_LEN    = 8,
    parameter bit         RSP_REPEAT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             pw_wdata,
    input  logic                   pw_wcmd,
    input  logic                   pw_wstb,
    input  logic                   pw_end,
    output logic                   pw_req,
    input  logic                   pw_gnt,
    output logic [7:0]             pw_rdata,
    input  logic                   pw_rstb,
    input  logic [8*RSP_LEN-1:0]   rsp_data,
    input  logic                   rsp_valid,
    output logic                   rsp_ready
);
    localparam int CW = $clog2(RSP_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(RSP_LEN - 1);
`ifdef SPI_SRESP_STATUS_EN
    localparam rd_state_t FIRST = RD_STATUS;
`else
    localparam rd_state_t FIRST = RD_DATA;
`endif
    rd_state_t state, nxt;
    logic [8*RSP_LEN-1:0] shreg;
    logic [CW-1:0] cnt;
    logic have, rel, start, take, last;
    // rel marks the cycle after a word-end pop, when the FIFO head already shows the next word
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= RD_IDLE;
        else     state <= nxt;
    end
    // next state, byte mux and pop strobe; pw_end wins over a simultaneous start
    always_comb begin
        start     = pw_wstb && pw_wcmd && (pw_wdata == CMD_BYTE);
        take      = pw_rstb && pw_gnt && !rel;
        last      = cnt == LAST;
        nxt       = state;
        pw_req    = state != RD_IDLE;
        pw_rdata  = 8'h00;
        rsp_ready = 1'b0;
        case (state)
            RD_STATUS: begin
                pw_rdata = {have, 7'd0};
                nxt      = take ? RD_DATA : state;
            end
            RD_DATA: begin
                pw_rdata  = shreg[8*RSP_LEN-1 -: 8];
                rsp_ready = take && last && have;
                nxt       = (take && last && !RSP_REPEAT) ? RD_DONE : state;
            end
            default: ;
        endcase
        nxt = start ? FIRST : nxt;
        nxt = pw_end ? RD_IDLE : nxt;
    end
    // shift register, byte counter and word reload
    always_ff @(posedge clk) begin
        if (rst || pw_end) begin
            shreg <= '0;
            have  <= 1'b0;
            cnt   <= '0;
            rel   <= 1'b0;
        end else if (start || rel) begin
            shreg <= rsp_valid ? rsp_data : '0;
            have  <= rsp_valid;
            cnt   <= start ? '0 : cnt;
            rel   <= 1'b0;
        end else if (state == RD_DATA && take) begin
            shreg <= shreg << 8;
            cnt   <= last ? '0 : cnt + 1'b1;
            rel   <= last && RSP_REPEAT;
        end
    end
endmodule
